// File: rtl/i2c_burst_master.sv
// I2C burst master: START, slave address, register byte, then a burst of
// len data bytes (write) or a repeated START plus len read bytes (read), STOP.
// Each bit takes four quarters of CLK_DIV clocks: SCL low in quarters 0-1 and
// high in quarters 2-3. SDA changes at quarter 0 and is sampled at the end of
// quarter 2.
// Optional feature: define I2C_NACK_RETRY_EN to retry an address NACK, up to
// three attempts in total, before reporting nack.
module i2c_burst_master #(
    parameter int CLK_DIV = 25,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             rw,
    input  logic [6:0]       addr,
    input  logic [7:0]       block_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       data_in,
    output logic             wr_ready,
    output logic [7:0]       data_out,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             nack,
    output logic             scl,
    inout  wire              sda
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
`ifdef I2C_NACK_RETRY_EN
    localparam logic [1:0]       LAST_TRY = 2'd2;
`else
    localparam logic [1:0]       LAST_TRY = 2'd0;
`endif

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, REG, ACK_R, RSTART, ADDR_R,
        ACK_AR, WDATA, ACK_W, RDATA, MACK, STOP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_q;
    logic [2:0]       r_bit;
    logic [7:0]       r_sh;
    logic [7:0]       r_rx;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_rw;
    logic [6:0]       r_addr;
    logic [7:0]       r_baddr;
    logic             r_nack_pend;
    logic             r_retry;
    logic [1:0]       r_try;
    logic             r_wr_ready;
    logic             r_rd_valid;
    logic             r_done;
    logic             r_nack;
    logic [7:0]       r_data_out;

    logic w_tick, w_bit_end, w_nak, w_last_bit, w_scl, w_sda_low;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_bit_end  = w_tick && (r_q == 2'd3);
    // In an ACK slot the only bit sampled so far is the acknowledge itself.
    assign w_nak      = r_rx[0];
    assign w_last_bit = (r_bit == 3'd0);

    assign wr_ready = r_wr_ready;
    assign rd_valid = r_rd_valid;
    assign done     = r_done;
    assign nack     = r_nack;
    assign data_out = r_data_out;
    assign busy     = (r_state != IDLE);
    assign scl      = w_scl;
    assign sda      = w_sda_low ? 1'b0 : 1'bz;

    // State register; reset drops straight to IDLE, releasing the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; everything except IDLE advances on bit boundaries.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = START;
            START:   if (w_bit_end) w_state_nxt = ADDR;
            ADDR:    if (w_bit_end && w_last_bit) w_state_nxt = ACK_A;
            ACK_A:   if (w_bit_end) w_state_nxt = w_nak ? STOP : REG;
            REG:     if (w_bit_end && w_last_bit) w_state_nxt = ACK_R;
            ACK_R: begin
                if (w_bit_end) begin
                    if (w_nak || r_cnt == '0) w_state_nxt = STOP;
                    else if (r_rw)            w_state_nxt = RSTART;
                    else                      w_state_nxt = WDATA;
                end
            end
            RSTART:  if (w_bit_end) w_state_nxt = ADDR_R;
            ADDR_R:  if (w_bit_end && w_last_bit) w_state_nxt = ACK_AR;
            ACK_AR:  if (w_bit_end) w_state_nxt = w_nak ? STOP : RDATA;
            WDATA:   if (w_bit_end && w_last_bit) w_state_nxt = ACK_W;
            ACK_W:   if (w_bit_end) w_state_nxt = (w_nak || r_cnt == '0) ? STOP : WDATA;
            RDATA:   if (w_bit_end && w_last_bit) w_state_nxt = MACK;
            MACK:    if (w_bit_end) w_state_nxt = (r_cnt == '0) ? STOP : RDATA;
            STOP:    if (w_bit_end) w_state_nxt = r_retry ? START : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus line levels per state and quarter; START/RSTART pull SDA low and
    // STOP releases it during the two SCL-high quarters 2-3.
    always_comb begin
        w_scl     = (r_q >= 2'd2);
        w_sda_low = 1'b0;
        case (r_state)
            IDLE:   w_scl = 1'b1;
            START: begin
                w_scl     = 1'b1;
                w_sda_low = (r_q >= 2'd2);
            end
            RSTART: begin
                w_scl     = (r_q != 2'd0);
                w_sda_low = (r_q >= 2'd2);
            end
            STOP: begin
                w_scl     = (r_q != 2'd0);
                w_sda_low = (r_q < 2'd2);
            end
            ADDR, REG, ADDR_R, WDATA: w_sda_low = ~r_sh[7];
            MACK:   w_sda_low = (r_cnt != '0);   // ACK unless this was the last byte
            default: w_sda_low = 1'b0;          // ACK slots and read bits: released
        endcase
    end

    // Datapath: divider, bit shifting, byte counter, handshakes and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div       <= '0;
            r_q         <= '0;
            r_bit       <= '0;
            r_sh        <= '0;
            r_rx        <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_baddr     <= '0;
            r_nack_pend <= 1'b0;
            r_retry     <= 1'b0;
            r_try       <= '0;
            r_wr_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            if (r_state == IDLE) begin
                r_div <= '0;
                r_q   <= '0;
                if (enable) begin
                    r_rw        <= rw;
                    r_addr      <= addr;
                    r_baddr     <= block_addr;
                    r_len       <= len;
                    r_cnt       <= len;
                    r_nack      <= 1'b0;
                    r_nack_pend <= 1'b0;
                    r_retry     <= 1'b0;
                    r_try       <= '0;
                end
            end else if (w_tick) begin
                r_div <= '0;
                r_q   <= r_q + 2'd1;
                if (r_q == 2'd2) r_rx <= {r_rx[6:0], sda};
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_bit_end) begin
                case (r_state)
                    START: begin
                        r_sh  <= {r_addr, 1'b0};
                        r_bit <= 3'd7;
                    end
                    ADDR, REG, ADDR_R: begin
                        r_bit <= r_bit - 3'd1;
                        r_sh  <= {r_sh[6:0], 1'b0};
                    end
                    ACK_A, ACK_AR: begin
                        r_bit <= 3'd7;
                        if (w_nak) begin
                            if (r_try != LAST_TRY) r_retry     <= 1'b1;
                            else                   r_nack_pend <= 1'b1;
                        end else if (r_state == ACK_A) begin
                            r_sh <= r_baddr;
                        end
                    end
                    ACK_R, ACK_W: begin
                        r_bit <= 3'd7;
                        if (w_nak) begin
                            r_nack_pend <= 1'b1;
                        end else if (r_cnt != '0 && !(r_state == ACK_R && r_rw)) begin
                            r_sh       <= data_in;
                            r_wr_ready <= 1'b1;
                        end
                    end
                    RSTART: begin
                        r_sh  <= {r_addr, 1'b1};
                        r_bit <= 3'd7;
                    end
                    WDATA: begin
                        r_bit <= r_bit - 3'd1;
                        r_sh  <= {r_sh[6:0], 1'b0};
                        if (w_last_bit && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end
                    RDATA: begin
                        r_bit <= r_bit - 3'd1;
                        if (w_last_bit) begin
                            r_data_out <= r_rx;
                            r_rd_valid <= 1'b1;
                            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    MACK: r_bit <= 3'd7;
                    STOP: begin
                        if (r_retry) begin
                            // Whole transaction restarts from START.
                            r_retry <= 1'b0;
                            r_try   <= r_try + 2'd1;
                            r_cnt   <= r_len;
                        end else begin
                            r_done <= 1'b1;
                            r_nack <= r_nack_pend;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_burst_master.sv
// Bench for i2c_burst_master: a behavioural I2C slave on the bus, scoreboard
// queues of expected bus bytes / read data, one task per scenario.
module tb_i2c_burst_master;

    localparam int CLK_DIV = 4;
    localparam int LEN_W   = 4;
    localparam int BUDGET  = 6000;
`ifdef I2C_NACK_RETRY_EN
    localparam int TRIES = 3;
`else
    localparam int TRIES = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             rw;
    logic [6:0]       addr;
    logic [7:0]       block_addr;
    logic [LEN_W-1:0] len;
    logic [7:0]       data_in;
    logic             wr_ready, rd_valid, busy, done, nack, scl;
    logic [7:0]       data_out;
    wire              sda;

    logic slv_drv = 1'b0;
    assign sda = slv_drv ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_burst_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rw(rw), .addr(addr),
        .block_addr(block_addr), .len(len), .data_in(data_in),
        .wr_ready(wr_ready), .data_out(data_out), .rd_valid(rd_valid),
        .busy(busy), .done(done), .nack(nack), .scl(scl), .sda(sda)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard queues
    logic [7:0] exp_bus[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_rd[$];
    logic [7:0] obs_rd[$];
    logic [7:0] tx_q[$];
    logic [7:0] wq[$];
    logic       mack_q[$];
    int starts, stops;

    // slave configuration
    bit         slv_present = 1'b1;
    logic [6:0] slv_addr    = 7'h69;
    int         nak_at      = -1;

    // slave internals
    logic p_scl = 1'b1, p_sda = 1'b1, c_scl, c_sda, ackbit, ack;
    int   nb = 0, byten = 0;
    logic [7:0] sh = 8'h00, txsh = 8'h00;
    bit   tx_next = 0, slv_tx = 0;

    // Behavioural slave: decodes START/STOP/bits from sampled lines and
    // drives ACKs and read data right after SCL falls.
    always @(negedge clk) begin
        c_scl = scl;
        c_sda = sda;
        if (c_scl === 1'b1 && p_scl === 1'b1 && p_sda === 1'b1 && c_sda === 1'b0) begin
            starts++; nb = 0; byten = 0; slv_tx = 0; tx_next = 0; slv_drv = 1'b0;
        end else if (c_scl === 1'b1 && p_scl === 1'b1 && p_sda === 1'b0 && c_sda === 1'b1) begin
            stops++; slv_tx = 0; tx_next = 0; slv_drv = 1'b0;
        end else if (p_scl === 1'b0 && c_scl === 1'b1) begin
            if (nb < 8) sh = {sh[6:0], c_sda};
            else        ackbit = c_sda;
            nb++;
        end else if (p_scl === 1'b1 && c_scl === 1'b0) begin
            if (nb == 8) begin
                if (slv_tx) slv_drv = 1'b0;
                else begin
                    rx_q.push_back(sh);
                    if (byten == 0) begin
                        ack     = slv_present && (sh[7:1] == slv_addr);
                        tx_next = ack && sh[0];
                        slv_drv = ack;
                    end else begin
                        slv_drv = (byten != nak_at);
                    end
                end
            end else if (nb >= 9) begin
                if (slv_tx) mack_q.push_back(ackbit);
                nb = 0;
                byten++;
                if (tx_next || (slv_tx && ackbit == 1'b0 && tx_q.size() > 0)) begin
                    slv_tx = 1; tx_next = 0;
                    txsh = tx_q.pop_front();
                    slv_drv = ~txsh[7];
                end else begin
                    slv_tx = 0; slv_drv = 1'b0;
                end
            end else if (slv_tx && nb > 0) begin
                slv_drv = ~txsh[7-nb];
            end
        end
        p_scl = c_scl;
        p_sda = c_sda;
    end

    task automatic clr_sb();
        exp_bus.delete(); rx_q.delete(); exp_rd.delete(); obs_rd.delete();
        tx_q.delete(); wq.delete(); mack_q.delete();
        starts = 0; stops = 0;
        slv_present = 1'b1; slv_addr = 7'h69; nak_at = -1;
    endtask

    task automatic kick(input logic r, input logic [6:0] a, input logic [7:0] b,
                        input logic [LEN_W-1:0] l);
        rw = r; addr = a; block_addr = b; len = l;
        data_in = (wq.size() > 0) ? wq.pop_front() : 8'h00;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    // Runs cycles until done (or budget), feeding data_in and collecting reads.
    task automatic wait_done(output bit to, output int wrc, output int busy_low);
        to = 1; wrc = 0; busy_low = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                wrc++;
                data_in = (wq.size() > 0) ? wq.pop_front() : 8'h00;
            end
            if (rd_valid) obs_rd.push_back(data_out);
            if (done) begin to = 0; break; end
            if (!busy) busy_low++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; rw = 1'b0; addr = '0; block_addr = '0;
        len = '0; data_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (scl !== 1'b1)      begin n_bad++; $display("FAIL reset_scl: got %b want 1", scl); end
        n_cmp++; if (sda !== 1'b1)      begin n_bad++; $display("FAIL reset_sda: got %b want released", sda); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (nack !== 1'b0)     begin n_bad++; $display("FAIL reset_nack: got %b want 0", nack); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_burst();
        bit to; int wrc, bl;
        logic [7:0] e;
        clr_sb();
        wq = '{8'h95, 8'h3C, 8'hA0};
        exp_bus = '{8'hD2, 8'h8D, 8'h95, 8'h3C, 8'hA0};
        kick(1'b0, 7'h69, 8'h8D, 4'd3);
        wait_done(to, wrc, bl);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL wr_timeout: no done within %0d cycles", BUDGET); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL wr_bus_byte: got none want %h", e); end
            else if (rx_q[0] !== e) begin n_bad++; $display("FAIL wr_bus_byte: got %h want %h", rx_q[0], e); void'(rx_q.pop_front()); end
            else void'(rx_q.pop_front());
        end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL wr_extra_bytes: got %0d want 0", rx_q.size()); end
        n_cmp++; if (wrc != 3)  begin n_bad++; $display("FAIL wr_ready_count: got %0d want 3", wrc); end
        n_cmp++; if (nack !== 1'b0) begin n_bad++; $display("FAIL wr_nack: got %b want 0", nack); end
        n_cmp++; if (starts != 1 || stops != 1) begin n_bad++; $display("FAIL wr_start_stop: got %0d/%0d want 1/1", starts, stops); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL wr_busy: dropped %0d cycles want 0", bl); end
    endtask

    task automatic test_read_burst();
        bit to; int wrc, bl;
        logic [7:0] e;
        clr_sb();
        tx_q    = '{8'h95, 8'h3C};
        exp_rd  = '{8'h95, 8'h3C};
        exp_bus = '{8'hD2, 8'h8D, 8'hD3};
        kick(1'b1, 7'h69, 8'h8D, 4'd2);
        wait_done(to, wrc, bl);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rd_timeout: no done within %0d cycles", BUDGET); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL rd_bus_byte: got none want %h", e); end
            else if (rx_q[0] !== e) begin n_bad++; $display("FAIL rd_bus_byte: got %h want %h", rx_q[0], e); void'(rx_q.pop_front()); end
            else void'(rx_q.pop_front());
        end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            n_cmp++;
            if (obs_rd.size() == 0) begin n_bad++; $display("FAIL rd_data_out: got none want %h", e); end
            else if (obs_rd[0] !== e) begin n_bad++; $display("FAIL rd_data_out: got %h want %h", obs_rd[0], e); void'(obs_rd.pop_front()); end
            else void'(obs_rd.pop_front());
        end
        n_cmp++; if (obs_rd.size() != 0) begin n_bad++; $display("FAIL rd_extra_valid: got %0d want 0", obs_rd.size()); end
        n_cmp++; if (mack_q.size() != 2 || mack_q[0] !== 1'b0 || mack_q[1] !== 1'b1)
                     begin n_bad++; $display("FAIL rd_master_ack: got %0d bits want ACK,NACK", mack_q.size()); end
        n_cmp++; if (starts != 2 || stops != 1) begin n_bad++; $display("FAIL rd_start_stop: got %0d/%0d want 2/1", starts, stops); end
        n_cmp++; if (wrc != 0) begin n_bad++; $display("FAIL rd_wr_ready: got %0d want 0", wrc); end
        n_cmp++; if (nack !== 1'b0) begin n_bad++; $display("FAIL rd_nack: got %b want 0", nack); end
    endtask

    task automatic test_data_nack();
        bit to; int wrc, bl;
        logic [7:0] e;
        clr_sb();
        nak_at  = 3;   // byte 0 addr, 1 reg, 2 first data, 3 second data
        wq      = '{8'h11, 8'h22, 8'h33};
        exp_bus = '{8'hD2, 8'h8D, 8'h11, 8'h22};
        kick(1'b0, 7'h69, 8'h8D, 4'd3);
        wait_done(to, wrc, bl);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL dn_timeout: no done within %0d cycles", BUDGET); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL dn_bus_byte: got none want %h", e); end
            else if (rx_q[0] !== e) begin n_bad++; $display("FAIL dn_bus_byte: got %h want %h", rx_q[0], e); void'(rx_q.pop_front()); end
            else void'(rx_q.pop_front());
        end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL dn_extra_bytes: got %0d want 0", rx_q.size()); end
        n_cmp++; if (wrc != 2) begin n_bad++; $display("FAIL dn_wr_ready_count: got %0d want 2", wrc); end
        n_cmp++; if (nack !== 1'b1) begin n_bad++; $display("FAIL dn_nack: got %b want 1", nack); end
        n_cmp++; if (stops != 1) begin n_bad++; $display("FAIL dn_stop: got %0d want 1", stops); end
    endtask

    task automatic test_addr_nack();
        bit to; int wrc, bl;
        clr_sb();
        slv_present = 1'b0;
        wq = '{8'h55};
        kick(1'b0, 7'h69, 8'h8D, 4'd1);
        wait_done(to, wrc, bl);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL an_timeout: no done within %0d cycles", BUDGET); end
        n_cmp++; if (starts != TRIES || stops != TRIES)
                     begin n_bad++; $display("FAIL an_start_stop: got %0d/%0d want %0d/%0d", starts, stops, TRIES, TRIES); end
        n_cmp++; if (rx_q.size() != TRIES) begin n_bad++; $display("FAIL an_addr_bytes: got %0d want %0d", rx_q.size(), TRIES); end
        n_cmp++; if (nack !== 1'b1) begin n_bad++; $display("FAIL an_nack: got %b want 1", nack); end
        n_cmp++; if (wrc != 0) begin n_bad++; $display("FAIL an_wr_ready: got %0d want 0", wrc); end
        n_cmp++; if (bl != 0) begin n_bad++; $display("FAIL an_busy: dropped %0d cycles want 0", bl); end
    endtask

    task automatic test_back_to_back();
        bit to; int wrc, bl;
        logic [7:0] e;
        clr_sb();
        exp_bus = '{8'hD2, 8'h8D, 8'hD2, 8'h42};
        rw = 1'b0; addr = 7'h69; block_addr = 8'h8D; len = '0; data_in = 8'h00;
        enable = 1'b1;
        @(negedge clk);
        block_addr = 8'h42;   // enable stays high: must be ignored while busy
        wait_done(to, wrc, bl);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout1: no done within %0d cycles", BUDGET); end
        @(negedge clk);
        enable = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: got busy %b want 1", busy); end
        wait_done(to, wrc, bl);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout2: no done within %0d cycles", BUDGET); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL b2b_bus_byte: got none want %h", e); end
            else if (rx_q[0] !== e) begin n_bad++; $display("FAIL b2b_bus_byte: got %h want %h", rx_q[0], e); void'(rx_q.pop_front()); end
            else void'(rx_q.pop_front());
        end
        n_cmp++; if (starts != 2 || stops != 2) begin n_bad++; $display("FAIL b2b_start_stop: got %0d/%0d want 2/2", starts, stops); end
        n_cmp++; if (nack !== 1'b0) begin n_bad++; $display("FAIL b2b_nack: got %b want 0", nack); end
    endtask

    task automatic test_reset_mid();
        bit to; int wrc, bl, cnt;
        logic [7:0] e;
        clr_sb();
        wq = '{8'hAA, 8'hBB, 8'hCC};
        kick(1'b0, 7'h69, 8'h8D, 4'd3);
        cnt = 0;
        for (int i = 0; i < BUDGET && cnt < 2; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                cnt++;
                data_in = (wq.size() > 0) ? wq.pop_front() : 8'h00;
            end
        end
        n_cmp++; if (cnt != 2) begin n_bad++; $display("FAIL rm_second_byte: got %0d wr_ready want 2", cnt); end
        repeat (20) @(negedge clk);   // inside the 2nd data byte
        reset = 1'b1;
        #1;
        n_cmp++; if (scl !== 1'b1)  begin n_bad++; $display("FAIL rm_scl: got %b want 1", scl); end
        n_cmp++; if (sda !== 1'b1)  begin n_bad++; $display("FAIL rm_sda: got %b want released", sda); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL rm_data_out: got %h want 00", data_out); end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        clr_sb();
        exp_bus = '{8'hD2, 8'h8D};
        kick(1'b0, 7'h69, 8'h8D, 4'd0);
        wait_done(to, wrc, bl);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rm_timeout: no done within %0d cycles", BUDGET); end
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL rm_bus_byte: got none want %h", e); end
            else if (rx_q[0] !== e) begin n_bad++; $display("FAIL rm_bus_byte: got %h want %h", rx_q[0], e); void'(rx_q.pop_front()); end
            else void'(rx_q.pop_front());
        end
        n_cmp++; if (nack !== 1'b0) begin n_bad++; $display("FAIL rm_nack: got %b want 0", nack); end
        n_cmp++; if (wrc != 0) begin n_bad++; $display("FAIL rm_wr_ready: got %0d want 0", wrc); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_data_nack();
        test_addr_nack();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
